// File: rtl/pin_input_conditioner.sv
// Pad input conditioner: per-pin ASYNC_REG synchroniser, output pipeline, programmable glitch
// filter and registered rise/fall pulses. Define PIN_EDGE_LATCH_EN to build sticky edge flags.
module pin_input_conditioner #(
    parameter int                WIDTH           = 32,
    parameter int                SYNC_STAGES     = 2,
    parameter int                PIPELINE_STAGES = 2,
    parameter logic [WIDTH-1:0]  INIT            = {WIDTH{1'b0}},
    parameter int                FILTER_BITS     = 4
) (
    input  logic                   clock_160,
    input  logic                   inp_resn,
    input  logic [WIDTH-1:0]       pin_in,
    input  logic [WIDTH-1:0]       filt_en,
    input  logic [FILTER_BITS-1:0] filt_len,
    output logic [WIDTH-1:0]       pin_sync,
    output logic [WIDTH-1:0]       rise,
    output logic [WIDTH-1:0]       fall,
    input  logic [WIDTH-1:0]       edge_clr,
    output logic [WIDTH-1:0]       edge_flag
);

    localparam logic [WIDTH-1:0]       ZERO_W = {WIDTH{1'b0}};
    localparam logic [FILTER_BITS-1:0] ZERO_C = {FILTER_BITS{1'b0}};
    localparam logic [FILTER_BITS-1:0] ONES_C = {FILTER_BITS{1'b1}};

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("pin_input_conditioner: SYNC_STAGES must be >= 2");
        end
        if (FILTER_BITS < 1) begin : g_bad_filter
            $error("pin_input_conditioner: FILTER_BITS must be >= 1");
        end
        if ((PIPELINE_STAGES < 0) || (PIPELINE_STAGES > 8)) begin : g_bad_pipe
            $error("pin_input_conditioner: PIPELINE_STAGES must be 0..8");
        end
    endgenerate

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] raw_s;

    // Synchroniser chain capturing the asynchronous pads.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= INIT;
            end
        end else begin
            sync_r[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    generate
        if (PIPELINE_STAGES == 0) begin : g_no_pipe
            assign raw_s = sync_r[SYNC_STAGES-1];
        end else begin : g_pipe
            (* shreg_extract = "no" *) logic [WIDTH-1:0] pipe_r [PIPELINE_STAGES];

            // Retiming pipeline between the synchroniser and the filter.
            always_ff @(posedge clock_160 or negedge inp_resn) begin
                if (!inp_resn) begin
                    for (int s = 0; s < PIPELINE_STAGES; s++) begin
                        pipe_r[s] <= INIT;
                    end
                end else begin
                    pipe_r[0] <= sync_r[SYNC_STAGES-1];
                    for (int s = 1; s < PIPELINE_STAGES; s++) begin
                        pipe_r[s] <= pipe_r[s-1];
                    end
                end
            end

            assign raw_s = pipe_r[PIPELINE_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0]       pin_sync_r;
    logic [WIDTH-1:0]       rise_r;
    logic [WIDTH-1:0]       fall_r;
    logic [FILTER_BITS-1:0] cnt_r       [WIDTH];
    logic [FILTER_BITS-1:0] cnt_nxt_s   [WIDTH];
    logic [FILTER_BITS-1:0] thr_s       [WIDTH];
    logic [WIDTH-1:0]       pin_sync_nxt_s;
    logic [WIDTH-1:0]       rise_nxt_s;
    logic [WIDTH-1:0]       fall_nxt_s;

    // Per-pin filter: accept raw once it has disagreed for more than the threshold.
    always_comb begin
        pin_sync_nxt_s = pin_sync_r;
        rise_nxt_s     = ZERO_W;
        fall_nxt_s     = ZERO_W;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = ZERO_C;
            thr_s[i]     = filt_en[i] ? filt_len : ZERO_C;
            if (raw_s[i] == pin_sync_r[i]) begin
                cnt_nxt_s[i] = ZERO_C;
            end else if (cnt_r[i] >= thr_s[i]) begin
                // The >= compare lets a lowered threshold release a pending pin at once.
                pin_sync_nxt_s[i] = raw_s[i];
                rise_nxt_s[i]     = raw_s[i];
                fall_nxt_s[i]     = ~raw_s[i];
                cnt_nxt_s[i]      = ZERO_C;
            end else if (cnt_r[i] != ONES_C) begin
                cnt_nxt_s[i] = cnt_r[i] + FILTER_BITS'(1);
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Filter state, filtered pin value and edge pulses.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            pin_sync_r <= INIT;
            rise_r     <= ZERO_W;
            fall_r     <= ZERO_W;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= ZERO_C;
            end
        end else begin
            pin_sync_r <= pin_sync_nxt_s;
            rise_r     <= rise_nxt_s;
            fall_r     <= fall_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign pin_sync = pin_sync_r;
    assign rise     = rise_r;
    assign fall     = fall_r;

`ifdef PIN_EDGE_LATCH_EN
    logic [WIDTH-1:0] edge_flag_r;

    // Sticky edge flags; a new edge wins over a clear in the same cycle.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            edge_flag_r <= ZERO_W;
        end else begin
            edge_flag_r <= (edge_flag_r & ~edge_clr) | rise_r | fall_r;
        end
    end

    assign edge_flag = edge_flag_r;
`else
    logic unused_edge_clr_s;

    assign unused_edge_clr_s = ^edge_clr;
    assign edge_flag         = ZERO_W;
`endif

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed plus randomized bench for pin_input_conditioner, checked against a
// cycle-level behavioural model built from a sample-history queue and run lengths.
module tb_pin_input_conditioner;

    localparam int          WIDTH  = 32;
    localparam int          SYNC   = 2;
    localparam int          PIPE   = 2;
    localparam int          FB     = 4;
    localparam int          LAT    = SYNC + PIPE;
    localparam logic [31:0] INIT_V = 32'h0000_00F0;
`ifdef PIN_EDGE_LATCH_EN
    localparam logic [31:0] LATCH  = 32'h1;
`else
    localparam logic [31:0] LATCH  = 32'h0;
`endif

    logic        clock_160 = 1'b0;
    logic        inp_resn  = 1'b1;
    logic [31:0] pin_in    = 32'h0;
    logic [31:0] filt_en   = 32'h0;
    logic [3:0]  filt_len  = 4'h0;
    logic [31:0] edge_clr  = 32'h0;
    logic [31:0] pin_sync, rise, fall, edge_flag;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] hist [$];
    logic [31:0] m_ps, m_rise, m_fall, m_flag;
    int          run [WIDTH];

    always #5 clock_160 = ~clock_160;

    pin_input_conditioner #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .PIPELINE_STAGES(PIPE),
        .INIT(INIT_V), .FILTER_BITS(FB)
    ) dut (
        .clock_160(clock_160), .inp_resn(inp_resn), .pin_in(pin_in),
        .filt_en(filt_en), .filt_len(filt_len), .pin_sync(pin_sync),
        .rise(rise), .fall(fall), .edge_clr(edge_clr), .edge_flag(edge_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < LAT; k++) hist.push_back(INIT_V);
        m_ps = INIT_V; m_rise = 32'h0; m_fall = 32'h0; m_flag = 32'h0;
        for (int i = 0; i < WIDTH; i++) run[i] = 0;
    endtask

    // raw seen by the filter at this edge is the pad sample taken LAT edges earlier.
    task automatic model_edge();
        logic [31:0] raw;
        int          neff;
        raw = hist.pop_front();
        hist.push_back(pin_in);
        if (LATCH != 32'h0) m_flag = (m_flag & ~edge_clr) | m_rise | m_fall;
        else                m_flag = 32'h0;
        m_rise = 32'h0;
        m_fall = 32'h0;
        for (int i = 0; i < WIDTH; i++) begin
            neff = filt_en[i] ? int'(filt_len) : 0;
            if (raw[i] == m_ps[i]) begin
                run[i] = 0;
            end else if (run[i] >= neff) begin
                m_ps[i] = raw[i];
                run[i]  = 0;
                if (raw[i]) m_rise[i] = 1'b1;
                else        m_fall[i] = 1'b1;
            end else if (run[i] < (1 << FB) - 1) begin
                run[i] = run[i] + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pin_sync"},  pin_sync,  m_ps);
        check({tag, "_rise"},      rise,      m_rise);
        check({tag, "_fall"},      fall,      m_fall);
        check({tag, "_edge_flag"}, edge_flag, m_flag);
    endtask

    task automatic step(input string tag);
        @(posedge clock_160);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        #1 inp_resn = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clock_160);
        @(posedge clock_160);
        #1;
        check_all("reset_hold");
        @(negedge clock_160);
        inp_resn = 1'b1;
    endtask

    initial begin
        int          rise_at, fall_at, nrise;
        logic [31:0] seen;

        // Reset value INIT, then bits 7:4 fall five edges after release.
        do_reset();
        check("init_pin_sync", pin_sync, 32'h0000_00F0);
        for (int c = 1; c <= 6; c++) begin
            step("init");
            if (c == 4) check("init_hold", pin_sync, 32'h0000_00F0);
            if (c == 5) begin
                check("init_fall", fall, 32'h0000_00F0);
                check("init_low", pin_sync, 32'h0);
            end
            if (c == 6) check("init_fall_once", fall, 32'h0);
        end

        // Bypass latency on pin 3.
        pin_in[3] = 1'b1;
        seen = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            step("bypass");
            seen |= fall;
            if (c == 4) check("byp_early", rise, 32'h0);
            if (c == 5) begin
                check("byp_rise", rise, 32'h0000_0008);
                check("byp_sync", pin_sync, 32'h0000_0008);
            end
            if (c == 6) check("byp_rise_once", rise, 32'h0);
        end
        check("byp_no_fall", seen, 32'h0);
        pin_in[3] = 1'b0;
        repeat (8) step("settle");

        // Glitch reject on pin 0 with N=4: 4-cycle pulse dropped, 5-cycle pulse passes.
        filt_en  = 32'h1;
        filt_len = 4'd4;
        pin_in[0] = 1'b1;
        seen = 32'h0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) pin_in[0] = 1'b0;
            step("glitch4");
            seen |= rise | pin_sync;
        end
        check("glitch_suppressed", 32'(seen[0]), 32'h0);
        pin_in[0] = 1'b1;
        rise_at = 0;
        fall_at = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 6) pin_in[0] = 1'b0;
            step("glitch5");
            if (rise[0] && rise_at == 0) rise_at = c;
            if (fall[0] && fall_at == 0) fall_at = c;
        end
        check("glitch_rise_cycle", 32'(rise_at), 32'd9);
        check("glitch_fall_cycle", 32'(fall_at), 32'd14);

        // Threshold dropped from 15 to 2 after six pending cycles on pin 1.
        filt_en  = 32'h2;
        filt_len = 4'd15;
        pin_in[1] = 1'b1;
        rise_at = 0;
        nrise = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 11) filt_len = 4'd2;
            step("thr_drop");
            if (rise[1]) begin
                nrise++;
                if (rise_at == 0) rise_at = c;
            end
        end
        check("thr_rise_cycle", 32'(rise_at), 32'd11);
        check("thr_rise_count", 32'(nrise), 32'd1);
        pin_in[1] = 1'b0;
        filt_len  = 4'd0;
        repeat (8) step("settle");

        // Reset three cycles into a pending transition on pin 0, then a full 11-cycle restart.
        filt_en  = 32'h1;
        filt_len = 4'd10;
        pin_in[0] = 1'b1;
        repeat (7) step("pend");
        do_reset();
        check("rst_mid_sync", pin_sync, 32'h0000_00F0);
        check("rst_mid_rise", rise, 32'h0);
        rise_at = 0;
        for (int c = 1; c <= 20; c++) begin
            step("rst_restart");
            if (rise[0] && rise_at == 0) rise_at = c;
        end
        check("rst_rise_cycle", 32'(rise_at), 32'd15);

        // Sticky flag on pin 2: set beats a simultaneous clear, a later clear drops it.
        filt_en  = 32'h0;
        filt_len = 4'd0;
        pin_in[2] = 1'b1;
        repeat (5) step("latch");
        check("latch_rise", 32'(rise[2]), 32'h1);
        edge_clr[2] = 1'b1;
        step("latch_set");
        check("latch_set_wins", 32'(edge_flag[2]), LATCH);
        step("latch_clr");
        check("latch_cleared", 32'(edge_flag[2]), 32'h0);
        edge_clr = 32'h0;
        repeat (3) step("settle");

        // Randomized traffic with occasional configuration changes and resets.
        for (int k = 0; k < 800; k++) begin
            pin_in ^= $urandom & $urandom & $urandom;
            if ($urandom_range(0, 49) == 0) filt_en = $urandom;
            if ($urandom_range(0, 29) == 0) filt_len = 4'($urandom_range(0, 15));
            edge_clr = $urandom & $urandom;
            if ($urandom_range(0, 249) == 0) do_reset();
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
